// File: rtl/ex_wb_arbiter.sv
// Writeback arbiter: per-channel result FIFOs merged round-robin onto
// registered scoreboard writeback ports.
module ex_wb_arbiter #(
  parameter int unsigned NrChannels  = 4,
  parameter int unsigned NrWbPorts   = 2,
  parameter int unsigned BufDepth    = 2,
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned TransIdBits = 3,
  parameter int unsigned SrcW        = $clog2(NrChannels)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    flush_i,
  input  logic [NrChannels-1:0]                   ch_valid_i,
  output logic [NrChannels-1:0]                   ch_ready_o,
  input  logic [NrChannels-1:0][DataWidth-1:0]    ch_result_i,
  input  logic [NrChannels-1:0][TransIdBits-1:0]  ch_trans_id_i,
  input  logic [NrChannels-1:0]                   ch_ex_valid_i,
  output logic [NrWbPorts-1:0]                    wb_valid_o,
  output logic [NrWbPorts-1:0][DataWidth-1:0]     wb_result_o,
  output logic [NrWbPorts-1:0][TransIdBits-1:0]   wb_trans_id_o,
  output logic [NrWbPorts-1:0]                    wb_ex_valid_o,
  output logic [NrWbPorts-1:0][SrcW-1:0]          wb_src_o
);

  localparam int unsigned PtrW  = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam int unsigned CntW  = $clog2(BufDepth + 1);
  localparam int unsigned PortW = (NrWbPorts > 1) ? $clog2(NrWbPorts) : 1;

  typedef struct packed {
    logic [DataWidth-1:0]   result;
    logic [TransIdBits-1:0] trans_id;
    logic                   ex_valid;
  } entry_t;

  entry_t          mem_q  [NrChannels][BufDepth];
  logic [CntW-1:0] cnt_q  [NrChannels];
  logic [CntW-1:0] cnt_d  [NrChannels];
  logic [PtrW-1:0] wptr_q [NrChannels];
  logic [PtrW-1:0] wptr_d [NrChannels];
  logic [PtrW-1:0] rptr_q [NrChannels];
  logic [PtrW-1:0] rptr_d [NrChannels];
  logic [SrcW-1:0] rr_ptr_q, rr_ptr_d;

  logic [NrChannels-1:0]                 push;
  logic [NrChannels-1:0]                 grant;
  logic [NrWbPorts-1:0]                  port_vld;
  logic [NrWbPorts-1:0][SrcW-1:0]        port_src;
  int unsigned                           ngrant;
  int unsigned                           last_idx;
  int unsigned                           scan_idx;
  entry_t                                head_e;

  logic [NrWbPorts-1:0]                  wb_valid_q, wb_valid_d;
  logic [NrWbPorts-1:0][DataWidth-1:0]   wb_result_q, wb_result_d;
  logic [NrWbPorts-1:0][TransIdBits-1:0] wb_trans_id_q, wb_trans_id_d;
  logic [NrWbPorts-1:0]                  wb_ex_valid_q, wb_ex_valid_d;
  logic [NrWbPorts-1:0][SrcW-1:0]        wb_src_q, wb_src_d;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(BufDepth - 1)) return '0;
    return p + PtrW'(1);
  endfunction

  // Ready looks only at the registered count, so a full FIFO refuses even when popping.
  always_comb begin
    ch_ready_o = '0;
    push       = '0;
    for (int c = 0; c < NrChannels; c++) begin
      ch_ready_o[c] = (cnt_q[c] != CntW'(BufDepth)) & ~rst_i;
      push[c]       = ch_valid_i[c] & ch_ready_o[c] & ~flush_i;
    end
  end

  // Round-robin scan over FIFO heads; k-th grant goes to writeback port k.
  always_comb begin
    grant    = '0;
    port_vld = '0;
    port_src = '0;
    ngrant   = 0;
    last_idx = 0;
    scan_idx = 0;
    for (int unsigned i = 0; i < NrChannels; i++) begin
      scan_idx = (32'(rr_ptr_q) + i) % NrChannels;
      if ((cnt_q[SrcW'(scan_idx)] != '0) && (ngrant < NrWbPorts)) begin
        grant[SrcW'(scan_idx)]     = 1'b1;
        port_vld[PortW'(ngrant)]   = 1'b1;
        port_src[PortW'(ngrant)]   = SrcW'(scan_idx);
        ngrant                     = ngrant + 1;
        last_idx                   = scan_idx;
      end
    end
    rr_ptr_d = rr_ptr_q;
    if (ngrant != 0) rr_ptr_d = SrcW'((last_idx + 1) % NrChannels);
  end

  always_comb begin
    for (int c = 0; c < NrChannels; c++) begin
      cnt_d[c]  = cnt_q[c];
      wptr_d[c] = wptr_q[c];
      rptr_d[c] = rptr_q[c];
      if (push[c])  wptr_d[c] = ptr_inc(wptr_q[c]);
      if (grant[c]) rptr_d[c] = ptr_inc(rptr_q[c]);
      case ({push[c], grant[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + CntW'(1);
        2'b01:   cnt_d[c] = cnt_q[c] - CntW'(1);
        default: cnt_d[c] = cnt_q[c];
      endcase
    end
  end

  always_comb begin
    head_e        = '0;
    wb_valid_d    = '0;
    wb_result_d   = '0;
    wb_trans_id_d = '0;
    wb_ex_valid_d = '0;
    wb_src_d      = '0;
    for (int k = 0; k < NrWbPorts; k++) begin
      head_e        = mem_q[port_src[k]][rptr_q[port_src[k]]];
      wb_valid_d[k] = port_vld[k];
      if (port_vld[k]) begin
        wb_result_d[k]   = head_e.result;
        wb_trans_id_d[k] = head_e.trans_id;
        wb_ex_valid_d[k] = head_e.ex_valid;
        wb_src_d[k]      = port_src[k];
      end
    end
  end

  // Flush clears FIFO occupancy and writeback valid but keeps the round-robin pointer.
  always_ff @(posedge clk_i) begin
    if (rst_i || flush_i) begin
      for (int c = 0; c < NrChannels; c++) begin
        cnt_q[c]  <= '0;
        wptr_q[c] <= '0;
        rptr_q[c] <= '0;
      end
      wb_valid_q <= '0;
      if (rst_i) begin
        rr_ptr_q      <= '0;
        wb_result_q   <= '0;
        wb_trans_id_q <= '0;
        wb_ex_valid_q <= '0;
        wb_src_q      <= '0;
      end
    end else begin
      for (int c = 0; c < NrChannels; c++) begin
        cnt_q[c]  <= cnt_d[c];
        wptr_q[c] <= wptr_d[c];
        rptr_q[c] <= rptr_d[c];
      end
      rr_ptr_q      <= rr_ptr_d;
      wb_valid_q    <= wb_valid_d;
      wb_result_q   <= wb_result_d;
      wb_trans_id_q <= wb_trans_id_d;
      wb_ex_valid_q <= wb_ex_valid_d;
      wb_src_q      <= wb_src_d;
    end
  end

  always_ff @(posedge clk_i) begin
    for (int c = 0; c < NrChannels; c++) begin
      if (push[c]) mem_q[c][wptr_q[c]] <= {ch_result_i[c], ch_trans_id_i[c], ch_ex_valid_i[c]};
    end
  end

  assign wb_valid_o    = wb_valid_q;
  assign wb_result_o   = wb_result_q;
  assign wb_trans_id_o = wb_trans_id_q;
  assign wb_ex_valid_o = wb_ex_valid_q;
  assign wb_src_o      = wb_src_q;

endmodule

// File: tb/tb_ex_wb_arbiter.sv
// Scoreboard bench for ex_wb_arbiter: queue-based reference model feeds an
// expected-output queue that a negedge monitor drains and compares.
module tb_ex_wb_arbiter;

  localparam int N = 4, M = 2, D = 2, DW = 64, TW = 3, SW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst, flush;
  logic [N-1:0]         vld, rdy;
  logic [N-1:0][DW-1:0] res;
  logic [N-1:0][TW-1:0] tid;
  logic [N-1:0]         ex;
  logic [M-1:0]         wbv, wbe;
  logic [M-1:0][DW-1:0] wbr;
  logic [M-1:0][TW-1:0] wbt;
  logic [M-1:0][SW-1:0] wbs;

  ex_wb_arbiter #(.NrChannels(N), .NrWbPorts(M), .BufDepth(D), .DataWidth(DW),
                  .TransIdBits(TW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .ch_valid_i(vld), .ch_ready_o(rdy), .ch_result_i(res), .ch_trans_id_i(tid),
    .ch_ex_valid_i(ex),
    .wb_valid_o(wbv), .wb_result_o(wbr), .wb_trans_id_o(wbt), .wb_ex_valid_o(wbe),
    .wb_src_o(wbs));

  // Single-port instance used for the fairness scenario.
  bit                   fair_en = 1'b0;
  logic                 flush2 = 1'b0;
  logic [N-1:0]         vld2, rdy2, ex2;
  logic [N-1:0][DW-1:0] res2 = '0;
  logic [N-1:0][TW-1:0] tid2 = '0;
  logic [0:0]           wbv2, wbe2;
  logic [0:0][DW-1:0]   wbr2;
  logic [0:0][TW-1:0]   wbt2;
  logic [0:0][SW-1:0]   wbs2;
  assign vld2 = fair_en ? 4'b1001 : 4'b0000;
  assign ex2  = '0;

  ex_wb_arbiter #(.NrChannels(N), .NrWbPorts(1), .BufDepth(D), .DataWidth(DW),
                  .TransIdBits(TW)) dut_fair (
    .clk_i(clk), .rst_i(rst), .flush_i(flush2),
    .ch_valid_i(vld2), .ch_ready_o(rdy2), .ch_result_i(res2), .ch_trans_id_i(tid2),
    .ch_ex_valid_i(ex2),
    .wb_valid_o(wbv2), .wb_result_o(wbr2), .wb_trans_id_o(wbt2), .wb_ex_valid_o(wbe2),
    .wb_src_o(wbs2));

  typedef struct packed {
    logic [DW-1:0] r;
    logic [TW-1:0] t;
    logic          e;
  } ent_t;

  typedef struct packed {
    logic [M-1:0]         v;
    logic [M-1:0][SW-1:0] s;
    ent_t [M-1:0]         e;
  } rec_t;

  ent_t mq [N][$];
  rec_t exp_q [$];
  int   rr_m = 0;
  bit   started = 1'b0;
  int   checks = 0, errors = 0;
  int   fair_exp = 0, fair_n = 0;
  logic [N-1:0][TW-1:0] tidc;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  // Reference model: each channel is a queue; each cycle grants go to the first
  // up-to-M non-empty queues found walking from the round-robin start index.
  always @(posedge clk) begin
    rec_t r;
    int ng, last, sc;
    bit [N-1:0] acc;
    r = '0;
    started = 1'b1;
    if (rst) begin
      for (int c = 0; c < N; c++) mq[c].delete();
      rr_m = 0;
    end else begin
      ng = 0;
      last = 0;
      for (int c = 0; c < N; c++) acc[c] = vld[c] && (mq[c].size() < D);
      for (int i = 0; i < N; i++) begin
        sc = (rr_m + i) % N;
        if (mq[sc].size() > 0 && ng < M) begin
          r.v[ng] = 1'b1;
          r.s[ng] = SW'(sc);
          r.e[ng] = mq[sc][0];
          ng++;
          last = sc;
        end
      end
      if (flush) begin
        for (int c = 0; c < N; c++) mq[c].delete();
        r = '0;
      end else begin
        for (int k = 0; k < ng; k++) void'(mq[r.s[k]].pop_front());
        for (int c = 0; c < N; c++)
          if (acc[c]) mq[c].push_back({res[c], tid[c], ex[c]});
        if (ng > 0) rr_m = (last + 1) % N;
      end
    end
    exp_q.push_back(r);
  end

  always @(negedge clk) begin
    rec_t r;
    if (started) begin
      for (int c = 0; c < N; c++)
        chk($sformatf("ready[%0d]", c), rdy[c], (!rst && mq[c].size() < D));
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sync: no expected record at %0t", $time);
      end else begin
        r = exp_q.pop_front();
        chk("wb_valid", wbv, r.v);
        for (int k = 0; k < M; k++) begin
          if (r.v[k]) begin
            chk($sformatf("wb_entry[%0d]", k), {wbr[k], wbt[k], wbe[k]}, r.e[k]);
            chk($sformatf("wb_src[%0d]", k), wbs[k], r.s[k]);
          end
        end
      end
    end
  end

  // Fairness: with ch0 and ch3 both busy, the single port must alternate 0,3,0,3...
  always @(negedge clk) begin
    if (fair_en && wbv2[0]) begin
      chk("fair_src", wbs2[0], fair_exp);
      fair_exp = (fair_exp == 0) ? 3 : 0;
      fair_n++;
    end
  end

  task automatic drive(input logic [N-1:0] v, input logic fl, input logic rs);
    vld = v;
    flush = fl;
    rst = rs;
    for (int c = 0; c < N; c++) begin
      res[c] = {$urandom, $urandom};
      tid[c] = tidc[c];
      ex[c]  = 1'($urandom_range(0, 1));
      if (v[c]) tidc[c] = tidc[c] + 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tidc = '0;
    drive(4'hF, 1'b0, 1'b1); tick();
    drive(4'hF, 1'b0, 1'b1); tick();

    drive(4'h0, 1'b0, 1'b0);
    fair_en = 1'b1;
    repeat (30) tick();
    fair_en = 1'b0;
    repeat (6) tick();
    chk("fair_count", (fair_n >= 20), 1'b1);

    drive(4'b0100, 1'b0, 1'b0);
    res[2] = 64'hDEAD; tid[2] = 3'd5; ex[2] = 1'b0;
    tick();
    drive(4'h0, 1'b0, 1'b0); repeat (4) tick();

    drive(4'h0, 1'b0, 1'b1); tick();
    drive(4'h0, 1'b0, 1'b0); tick();
    drive(4'hF, 1'b0, 1'b0); tick();
    drive(4'h0, 1'b0, 1'b0); repeat (4) tick();

    repeat (20) begin drive(4'hF, 1'b0, 1'b0); tick(); end
    drive(4'h0, 1'b0, 1'b0); repeat (6) tick();

    repeat (3) begin drive(4'hF, 1'b0, 1'b0); tick(); end
    drive(4'b0010, 1'b1, 1'b0); tick();
    drive(4'h0, 1'b0, 1'b0); tick();
    drive(4'b0010, 1'b0, 1'b0); tick();
    drive(4'h0, 1'b0, 1'b0); repeat (4) tick();

    repeat (400) begin
      drive(N'($urandom), ($urandom_range(0, 29) == 0), ($urandom_range(0, 99) == 0));
      tick();
    end
    drive(4'h0, 1'b0, 1'b0); repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
